// File: rtl/mem_initiator.sv
// Host-side initiator for the 8x4 dual-port RAM: turns single-beat READ/WRITE/CLEAR
// commands into registered port A/B drives and returns read data with a done pulse.
module mem_initiator #(
    parameter int AW    = 3,
    parameter int DW    = 4,
    parameter int DEPTH = 2**AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic [1:0]    cmd,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          ready,
    output logic          done,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr_a,
    output logic          mem_rw_a,
    output logic [DW-1:0] mem_din_a,
    input  logic [DW-1:0] mem_dout_a,
    output logic [AW-1:0] mem_addr_b,
    output logic          mem_rw_b,
    output logic [DW-1:0] mem_din_b,
    input  logic [DW-1:0] mem_dout_b,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR       = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        CLR      = 3'd4
    } state_t;

    localparam int KW = AW - 1;
    localparam logic [KW-1:0] K_LAST = KW'(DEPTH/2 - 1);

    state_t        state, state_nxt;
    logic [KW-1:0] k, k_nxt, k_inc;
    logic          nop_pend, nop_pend_nxt;
    logic          done_nxt;
    logic          rdata_load;
    logic          accept;
    logic [AW-1:0] addr_a_nxt, addr_b_nxt;
    logic          rw_a_nxt, rw_b_nxt;
    logic [DW-1:0] din_a_nxt, din_b_nxt;

    // Handshake: a command transfers on a rising edge where req && ready; req seen
    // while ready is low is neither accepted nor queued, and done pulses on completion.
    assign ready     = (state == IDLE);
    assign accept    = req && ready;
    assign k_inc     = k + 1'b1;
    assign dbg_state = state;

    // Port B is write-only from this block's point of view.
    logic unused_dout_b;
    assign unused_dout_b = ^mem_dout_b;

    always_comb begin
        state_nxt    = state;
        k_nxt        = k;
        nop_pend_nxt = 1'b0;
        done_nxt     = nop_pend;
        rdata_load   = 1'b0;
        addr_a_nxt   = '0;
        rw_a_nxt     = 1'b0;
        din_a_nxt    = '0;
        addr_b_nxt   = '0;
        rw_b_nxt     = 1'b0;
        din_b_nxt    = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (cmd)
                        2'b00: begin
                            state_nxt  = RD_ISSUE;
                            addr_a_nxt = addr;
                        end
                        2'b01: begin
                            state_nxt  = WR;
                            rw_a_nxt   = 1'b1;
                            addr_a_nxt = addr;
                            din_a_nxt  = wdata;
                        end
                        2'b10: begin
                            state_nxt  = CLR;
                            k_nxt      = '0;
                            rw_a_nxt   = 1'b1;
                            rw_b_nxt   = 1'b1;
                            addr_b_nxt = AW'(1);
                        end
                        default: nop_pend_nxt = 1'b1;
                    endcase
                end
            end
            WR: begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
            RD_ISSUE: state_nxt = RD_WAIT;
            RD_WAIT: begin
                state_nxt  = IDLE;
                done_nxt   = 1'b1;
                rdata_load = 1'b1;
            end
            CLR: begin
                // Each beat zeroes the even/odd pair {k,0} and {k,1}, so ports never collide.
                if (k == K_LAST) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    k_nxt      = k_inc;
                    rw_a_nxt   = 1'b1;
                    rw_b_nxt   = 1'b1;
                    addr_a_nxt = {k_inc, 1'b0};
                    addr_b_nxt = {k_inc, 1'b1};
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            k          <= '0;
            nop_pend   <= 1'b0;
            done       <= 1'b0;
            rdata      <= '0;
            mem_addr_a <= '0;
            mem_rw_a   <= 1'b0;
            mem_din_a  <= '0;
            mem_addr_b <= '0;
            mem_rw_b   <= 1'b0;
            mem_din_b  <= '0;
        end else begin
            state      <= state_nxt;
            k          <= k_nxt;
            nop_pend   <= nop_pend_nxt;
            done       <= done_nxt;
            if (rdata_load) rdata <= mem_dout_a;
            mem_addr_a <= addr_a_nxt;
            mem_rw_a   <= rw_a_nxt;
            mem_din_a  <= din_a_nxt;
            mem_addr_b <= addr_b_nxt;
            mem_rw_b   <= rw_b_nxt;
            mem_din_b  <= din_b_nxt;
        end
    end

endmodule

// File: tb/tb_mem_initiator.sv
// Bench for mem_initiator: RAM stand-in, command-level reference model with a
// per-cycle expected queue, directed command sequences and literal spot checks.
module tb_mem_initiator;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic [1:0] cmd;
    logic [2:0] addr;
    logic [3:0] wdata;
    logic       ready;
    logic       done;
    logic [3:0] rdata;
    logic [2:0] mem_addr_a, mem_addr_b;
    logic       mem_rw_a, mem_rw_b;
    logic [3:0] mem_din_a, mem_din_b;
    logic [3:0] mem_dout_a, mem_dout_b;
    logic [2:0] dbg_state_unused;

    int errors = 0;
    int checks = 0;

    mem_initiator #(.AW(3), .DW(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .cmd(cmd), .addr(addr), .wdata(wdata),
        .ready(ready), .done(done), .rdata(rdata),
        .mem_addr_a(mem_addr_a), .mem_rw_a(mem_rw_a), .mem_din_a(mem_din_a), .mem_dout_a(mem_dout_a),
        .mem_addr_b(mem_addr_b), .mem_rw_b(mem_rw_b), .mem_din_b(mem_din_b), .mem_dout_b(mem_dout_b),
        .dbg_state(dbg_state_unused)
    );

    // Clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, act=running req=finished");
        $fatal(1, "watchdog");
    end

    // RAM stand-in: synchronous write, registered read on both ports
    logic [3:0] ram [8];
    initial for (int i = 0; i < 8; i++) ram[i] = 4'h0;
    always @(posedge clk) begin
        if (mem_rw_a) ram[mem_addr_a] <= mem_din_a;
        if (mem_rw_b) ram[mem_addr_b] <= mem_din_b;
        mem_dout_a <= ram[mem_addr_a];
        mem_dout_b <= ram[mem_addr_b];
    end

    // Reference model: memory contents, last read word and per-cycle expectations.
    // Vector layout: ready, done, rdata[3:0], rw_a, addr_a[2:0], din_a[3:0], rw_b, addr_b[2:0], din_b[3:0]
    localparam logic [21:0] M_ALL        = 22'h3FFFFF;
    localparam logic [21:0] M_NO_DIN_A   = ~22'h000F00;
    localparam logic [21:0] M_NO_PORTA_D = ~22'h007F00;

    logic [3:0]  ref_mem  [8];
    logic [3:0]  ref_save [8];
    logic [3:0]  last_rd = 4'h0;
    logic [21:0] exp_q[$];
    logic [21:0] mask_q[$];
    logic        model_ready = 1'b1;
    initial for (int i = 0; i < 8; i++) ref_mem[i] = 4'h0;

    function automatic logic [21:0] v(input logic rdy, input logic dn, input logic [3:0] rd,
                                      input logic rwa, input logic [2:0] aa, input logic [3:0] da,
                                      input logic rwb, input logic [2:0] ab, input logic [3:0] db);
        return {rdy, dn, rd, rwa, aa, da, rwb, ab, db};
    endfunction

    task automatic push(input logic [21:0] e, input logic [21:0] m);
        exp_q.push_back(e);
        mask_q.push_back(m);
    endtask

    // Expected cycles start with the cycle that follows the accepting edge.
    task automatic push_cmd(input logic [1:0] c, input logic [2:0] a, input logic [3:0] d);
        logic [3:0] r;
        case (c)
            2'b00: begin
                r = ref_mem[a];
                push(v(1'b0, 1'b0, last_rd, 1'b0, a, 4'h0, 1'b0, 3'd0, 4'h0), M_NO_DIN_A);
                push(v(1'b0, 1'b0, last_rd, 1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0), M_NO_PORTA_D);
                last_rd = r;
                push(v(1'b1, 1'b1, r, 1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0), M_ALL);
            end
            2'b01: begin
                push(v(1'b0, 1'b0, last_rd, 1'b1, a, d, 1'b0, 3'd0, 4'h0), M_ALL);
                push(v(1'b1, 1'b1, last_rd, 1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0), M_ALL);
                ref_mem[a] = d;
            end
            2'b10: begin
                for (int kk = 0; kk < 4; kk++)
                    push(v(1'b0, 1'b0, last_rd, 1'b1, 3'(2*kk), 4'h0, 1'b1, 3'(2*kk+1), 4'h0), M_ALL);
                push(v(1'b1, 1'b1, last_rd, 1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0), M_ALL);
                for (int i = 0; i < 8; i++) begin
                    ref_save[i] = ref_mem[i];
                    ref_mem[i]  = 4'h0;
                end
            end
            default: begin
                push(v(1'b1, 1'b0, last_rd, 1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0), M_ALL);
                push(v(1'b1, 1'b1, last_rd, 1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0), M_ALL);
            end
        endcase
    endtask

    // Reset during CLEAR after `pairs` beats: those words are zero, the rest keep old data.
    task automatic model_abort_clear(input int pairs);
        exp_q.delete();
        mask_q.delete();
        last_rd = 4'h0;
        for (int i = 0; i < 8; i++) ref_mem[i] = (i < 2*pairs) ? 4'h0 : ref_save[i];
    endtask

    // Scoreboard compare: one check per cycle, sampled on the falling edge
    logic [21:0] cmp_e, cmp_m, cmp_act;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cmp_e = exp_q.pop_front();
            cmp_m = mask_q.pop_front();
        end else begin
            cmp_e = v(1'b1, 1'b0, last_rd, 1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0);
            cmp_m = M_ALL;
        end
        model_ready = cmp_e[21];
        cmp_act = {ready, done, rdata, mem_rw_a, mem_addr_a, mem_din_a, mem_rw_b, mem_addr_b, mem_din_b};
        checks++;
        if ((cmp_act & cmp_m) !== (cmp_e & cmp_m)) begin
            errors++;
            $display("FAIL cycle_cmp t=%0t act=%h req=%h mask=%h", $time, cmp_act, cmp_e, cmp_m);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: act=%0d req=%0d", name, act, exp);
        end
    endtask

    // Driver tasks: called just after a rising edge
    task automatic send(input logic [1:0] c, input logic [2:0] a, input logic [3:0] d, output time acc_t);
        bit acc = 1'b0;
        req = 1'b1; cmd = c; addr = a; wdata = d;
        acc_t = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            if (model_ready) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) begin
            chk("accept_timeout", 0, 1);
        end else begin
            acc_t = $time;
            push_cmd(c, a, d);
        end
        #1;
        req = 1'b0; addr = ~a; wdata = ~d;
    endtask

    task automatic wait_done(input time acc_t, output int lat);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = int'(($time - acc_t) / 10);
                break;
            end
        end
        if (lat < 0) chk("done_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [1:0] c, input logic [2:0] a, input logic [3:0] d, output int lat);
        time t;
        send(c, a, d, t);
        wait_done(t, lat);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, int'(ready), 1);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_rdata"}, int'(rdata), 0);
        chk({tag, "_rw_a"}, int'(mem_rw_a), 0);
        chk({tag, "_rw_b"}, int'(mem_rw_b), 0);
        chk({tag, "_addr_a"}, int'(mem_addr_a), 0);
        chk({tag, "_addr_b"}, int'(mem_addr_b), 0);
    endtask

    int  lat;
    time t_clr, t_wr;

    initial begin
        rst_n = 1'b1; req = 1'b0; cmd = 2'b00; addr = 3'd0; wdata = 4'h0;
        #1 rst_n = 1'b0;
        #1 chk_reset_vals("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // WRITE then READ back
        run(2'b01, 3'd3, 4'h5, lat);
        chk("wr_latency", lat, 1);
        run(2'b00, 3'd3, 4'h0, lat);
        chk("rd_latency", lat, 2);
        chk("rd_data_3", int'(rdata), 5);

        // Fill with F, CLEAR, read every word back
        for (int i = 0; i < 8; i++) run(2'b01, 3'(i), 4'hF, lat);
        run(2'b10, 3'd0, 4'h0, lat);
        chk("clr_latency", lat, 4);
        for (int i = 0; i < 8; i++) begin
            run(2'b00, 3'(i), 4'h0, lat);
            chk("clr_read_zero", int'(rdata), 0);
        end

        // Busy rejection: WRITE held during CLEAR lands on the cycle after CLEAR's done
        send(2'b10, 3'd0, 4'h0, t_clr);
        send(2'b01, 3'd2, 4'hA, t_wr);
        chk("busy_accept_cycles", int'((t_wr - t_clr) / 10), 5);
        wait_done(t_wr, lat);
        chk("busy_wr_latency", lat, 1);
        run(2'b00, 3'd2, 4'h0, lat);
        chk("busy_rd_data_2", int'(rdata), 10);

        // Input stability: addr flips to 1 right after the READ of 6 is accepted
        run(2'b01, 3'd6, 4'h7, lat);
        run(2'b00, 3'd6, 4'h0, lat);
        chk("stable_rd_data_6", int'(rdata), 7);

        // Reset after the second CLEAR beat
        for (int i = 0; i < 8; i++) run(2'b01, 3'(i), 4'h9, lat);
        send(2'b10, 3'd0, 4'h0, t_clr);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        model_abort_clear(2);
        #1 chk_reset_vals("midclr_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            run(2'b00, 3'(i), 4'h0, lat);
            chk("midclr_read", int'(rdata), (i < 4) ? 0 : 9);
        end

        // Reserved command: done one cycle later, no access, rdata held
        run(2'b11, 3'd5, 4'hC, lat);
        chk("nop_latency", lat, 1);
        chk("nop_rdata_held", int'(rdata), 9);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_initiator.md
# mem_initiator

Host-side initiator for the 8x4 dual-port RAM (`memoria`). It turns single-beat host commands (READ, WRITE, CLEAR) into cycle-exact port A/B drives and returns read data. The handshake is simple: accept, then a completion pulse. It sits between the control logic and the RAM and is the only block that drives the RAM's address, rw and data-in pins.

## Interface

Parameters:
- AW, 3, address width; matches the RAM.
- DW, 4, data width; matches the RAM.
- DEPTH, 2**AW, number of words (8).

Ports (clock and reset first):
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- req, in, 1: command valid.
- cmd, in, 2: command code.
  - 00 READ
  - 01 WRITE
  - 10 CLEAR
  - 11 reserved, no-op
- addr, in, AW: target word for READ/WRITE.
- wdata, in, DW: write data for WRITE.
- ready, out, 1: high only in IDLE. A command is accepted at a rising edge with req && ready.
- done, out, 1: one-cycle completion pulse.
- rdata, out, DW: last read word. Valid from the done pulse of a READ and held until the next READ completes.
- mem_addr_a, out, AW: RAM port A address.
- mem_rw_a, out, 1: RAM port A mode, 1 = write, 0 = read.
- mem_din_a, out, DW: RAM port A write data.
- mem_dout_a, in, DW: RAM port A read data, registered inside the RAM.
- mem_addr_b, mem_rw_b, mem_din_b, mem_dout_b: same for port B.

## Operation

- FSM states: IDLE, WR, RD_ISSUE, RD_WAIT, CLR.
- IDLE:
  - Port A and B drive rw=0, addr=0, din=0. Reads are harmless; no spurious writes.
  - On accept, cmd, addr and wdata are latched. Later input changes have no effect.
- WRITE: IDLE→WR for 1 cycle. Drive mem_rw_a=1, mem_addr_a=addr, mem_din_a=wdata. Then →IDLE with done=1.
- READ: IDLE→RD_ISSUE for 1 cycle (mem_rw_a=0, mem_addr_a=addr), then →RD_WAIT for 1 cycle. At the end of RD_WAIT, rdata←mem_dout_a and done=1, then →IDLE.
- CLEAR: IDLE→CLR with a counter k = 0..DEPTH/2−1.
  - Each cycle: port A writes 0 to address 2k, port B writes 0 to address 2k+1, both rw=1.
  - The two ports always target distinct addresses, so there is no collision.
  - After k = DEPTH/2−1, go →IDLE with done=1.
- Reserved cmd 11: accepted, no memory access, done pulses on the next cycle, stays IDLE.
- Port B is driven only in CLR. Otherwise it holds idle values.
- All outputs except ready are registered. ready is decoded from state.

## Timing

- Edge E0 is the accepting edge. The state's port drives appear after E0.
- WRITE: RAM writes at E1. done is high E1→E2. ready is high again after E1, so the next accept is at E2 at the earliest.
- READ: RAM samples at E1, and mem_dout_a is valid after E1. rdata is captured at E2 and done is high E2→E3 with rdata valid. Next accept is at E3.
- CLEAR (DEPTH=8): writes at E1, E2, E3, E4 (pairs 0/1, 2/3, 4/5, 6/7). done is high E4→E5. Next accept is at E5.
- req while ready=0 is ignored and not queued. The host keeps req high until accepted.
- done and ready are high together in the first IDLE cycle after completion. A new req in that cycle is accepted at the following edge.
- Reset values (asynchronous, immediate on rst_n low):
  - state=IDLE, ready=1, done=0, rdata=0.
  - mem_rw_a=mem_rw_b=0, mem_addr_*=0, mem_din_*=0.
- Reset mid-operation:
  - A WR in flight is aborted: rw drops before the next edge and no write occurs.
  - A CLEAR is abandoned with partial zeroing; already-written words stay 0 and others keep prior contents.
  - A READ is abandoned with no done.
- Address has no wrap logic. Addr 7 is a legal word. The CLEAR counter stops at DEPTH/2−1 and never issues addresses ≥ DEPTH.

## Test plan

- WRITE addr=3, wdata=4'h5, then READ addr=3:
  - done at E1 after the write accept.
  - rdata=4'h5 with done at E2 after the read accept.
  - Port B rw stays 0 throughout.
- WRITE 4'hF to all 8 addresses, then CLEAR, then READ each address:
  - CLEAR done exactly 4 cycles after accept.
  - Ports A/B write pairs (0,1), (2,3), (4,5), (6,7) in order.
  - Every read returns 4'h0.
- Busy rejection: during a CLEAR, assert req with cmd=WRITE addr=2 wdata=4'hA.
  - Nothing is accepted while ready=0.
  - The write is accepted the cycle after CLEAR's done.
  - READ addr=2 returns 4'hA.
- Input stability: accept READ addr=6, then change addr to 1 the next cycle.
  - mem_addr_a stays 6.
  - rdata equals the word stored at 6.
- Reset mid-CLEAR: pull rst_n low after the second CLR cycle.
  - All outputs go to reset values immediately, with ready=1.
  - Addresses 0–3 read 0. Addresses 4–7 keep their pre-CLEAR values (e.g., 4'h9).
- Reserved cmd 11: done pulses at E1, with no mem_rw_a/b assertion and rdata unchanged.
